alu_op_sequencer: RTL and testbench

- Initiator side of the ALU interface: accepts one operation request per transaction and drives the ALU operand/op bus (A, B, sig_alu_op).
- Waits the ALU's clocked latency, captures the result and flags, and returns them on a valid/ready response channel.
- Sits between the multi-cycle control FSM and the ALU, replacing the directly-driven operand registers.

---
 rtl/alu_op_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// ALU request/response sequencer: issues one op to a clocked ALU, waits its latency, returns result+flags.
// Optional result chaining onto operand A is enabled by defining ALU_SEQ_CHAIN_EN.
module alu_op_sequencer #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_negative,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_negative,
  output logic             rsp_overflow,
  output logic             rsp_error,
  input  logic             clr_sticky,
  output logic             ovf_sticky
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_ILLEGAL = 2'b11;
  localparam logic [3:0] LAT        = 4'(ALU_LATENCY);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_neg_q, rsp_neg_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_err_q, rsp_err_d;
  logic             sticky_q, sticky_d;
  logic             sticky_set;
  logic [WIDTH-1:0] a_src;

`ifdef ALU_SEQ_CHAIN_EN
  // Chain source is kept apart from rsp_result so an illegal-op response (result 0) cannot replace it.
  logic             chain_valid_q, chain_valid_d;
  logic [WIDTH-1:0] chain_res_q, chain_res_d;

  assign a_src = (req_chain && chain_valid_q) ? chain_res_q : req_a;
`else
  logic unused_chain;

  assign unused_chain = req_chain;
  assign a_src        = req_a;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_neg_d    = rsp_neg_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_err_d    = rsp_err_q;
    sticky_set   = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
    chain_valid_d = chain_valid_q;
    chain_res_d   = chain_res_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_op != OP_ILLEGAL) begin
            alu_a_d  = a_src;
            alu_b_d  = req_b;
            alu_op_d = req_op;
            cnt_d    = LAT;
            state_d  = S_WAIT;
          end else begin
            rsp_result_d = '0;
            rsp_zero_d   = 1'b0;
            rsp_neg_d    = 1'b0;
            rsp_ovf_d    = 1'b0;
            rsp_err_d    = 1'b1;
            state_d      = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_result_d = alu_out;
          rsp_zero_d   = alu_zero;
          rsp_neg_d    = alu_negative;
          rsp_ovf_d    = alu_overflow;
          rsp_err_d    = 1'b0;
          sticky_set   = alu_overflow;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
`ifdef ALU_SEQ_CHAIN_EN
          if (!rsp_err_q) begin
            chain_valid_d = 1'b1;
            chain_res_d   = rsp_result_q;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A capture that sees overflow beats a simultaneous clear.
    if (sticky_set) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_neg_q    <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
      sticky_q     <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
      chain_valid_q <= 1'b0;
      chain_res_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_neg_q    <= rsp_neg_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_err_q    <= rsp_err_d;
      sticky_q     <= sticky_d;
`ifdef ALU_SEQ_CHAIN_EN
      chain_valid_q <= chain_valid_d;
      chain_res_q   <= chain_res_d;
`endif
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign rsp_valid    = (state_q == S_RESP);
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_negative = rsp_neg_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_error    = rsp_err_q;
  assign ovf_sticky   = sticky_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a one-cycle-latency ALU model attached to the alu_* bus.
module tb_alu_op_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        req_chain;
  logic [31:0] alu_a, alu_b;
  logic [1:0]  alu_op;
  logic [31:0] alu_out;
  logic        alu_zero, alu_negative, alu_overflow;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_negative, rsp_overflow, rsp_error;
  logic        clr_sticky, ovf_sticky;

  int n_checks = 0;
  int n_pass   = 0;
  int cycles;

  alu_op_sequencer #(.WIDTH(32), .ALU_LATENCY(1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_chain(req_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_negative(rsp_negative), .rsp_overflow(rsp_overflow),
    .rsp_error(rsp_error), .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky)
  );

  always #5 clock = ~clock;

  // Clocked ALU: result registered one edge after operands.
  always @(posedge clock) begin
    logic [31:0] r;
    logic        v;
    r = 32'd0;
    v = 1'b0;
    case (alu_op)
      2'b00: begin r = alu_a + alu_b; v = (alu_a[31] == alu_b[31]) && (r[31] != alu_a[31]); end
      2'b01: begin r = alu_a - alu_b; v = (alu_a[31] != alu_b[31]) && (r[31] != alu_a[31]); end
      2'b10: r = alu_a & alu_b;
      default: r = 32'd0;
    endcase
    alu_out      <= r;
    alu_zero     <= (r == 32'd0);
    alu_negative <= r[31];
    alu_overflow <= v;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic chain);
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_chain = chain;
    tick();
    req_valid = 1'b0;
    req_chain = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    if (!rsp_valid) check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0;
    req_chain = 1'b0; rsp_ready = 1'b1; clr_sticky = 1'b0;
    tick(); tick();
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_op", {30'd0, alu_op}, 32'd0);
    check("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
    reset = 1'b0;
    tick();

    // ADD 10+20
    issue(2'b00, 32'd10, 32'd20, 1'b0);
    check("add_alu_op", {30'd0, alu_op}, 32'd0);
    check("add_alu_a", alu_a, 32'd10);
    check("add_alu_b", alu_b, 32'd20);
    check("add_busy", {31'd0, req_ready}, 32'd0);
    wait_rsp(cycles);
    check("add_latency", cycles, 32'd2);
    check("add_result", rsp_result, 32'd30);
    check("add_flags", {29'd0, rsp_zero, rsp_negative, rsp_error}, 32'd0);
    tick();
    check("add_idle", {30'd0, req_ready, rsp_valid}, 32'd2);

    // SUB 50-50 then 50-100
    issue(2'b01, 32'd50, 32'd50, 1'b0);
    wait_rsp(cycles);
    check("sub0_result", rsp_result, 32'd0);
    check("sub0_zn", {30'd0, rsp_zero, rsp_negative}, 32'd2);
    tick();
    issue(2'b01, 32'd50, 32'd100, 1'b0);
    wait_rsp(cycles);
    check("subn_result", rsp_result, 32'hFFFF_FFCE);
    check("subn_znv", {29'd0, rsp_zero, rsp_negative, rsp_overflow}, 32'd2);
    tick();

    // AND with stalled consumer; a request during RESP must be ignored
    rsp_ready = 1'b0;
    issue(2'b10, 32'h0000_0F0F, 32'h0000_0FFF, 1'b0);
    wait_rsp(cycles);
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'd77; req_b = 32'd1;
    for (int i = 0; i < 3; i++) begin
      check("and_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("and_hold_result", rsp_result, 32'h0000_0F0F);
      check("and_hold_busy", {31'd0, req_ready}, 32'd0);
      tick();
    end
    check("and_ignored_a", alu_a, 32'h0000_0F0F);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("and_idle", {30'd0, req_ready, rsp_valid}, 32'd2);

    // Illegal op: bus untouched, immediate error response
    issue(2'b11, 32'd5, 32'd6, 1'b0);
    check("ill_bus_a", alu_a, 32'h0000_0F0F);
    check("ill_bus_b", alu_b, 32'h0000_0FFF);
    check("ill_bus_op", {30'd0, alu_op}, 32'd2);
    wait_rsp(cycles);
    check("ill_latency", cycles, 32'd0);
    check("ill_valid", {31'd0, rsp_valid}, 32'd1);
    check("ill_error", {31'd0, rsp_error}, 32'd1);
    check("ill_result", rsp_result, 32'd0);
    tick();

    // Overflow and sticky bit
    issue(2'b00, 32'h7FFF_FFFF, 32'd1, 1'b0);
    wait_rsp(cycles);
    check("ovf_result", rsp_result, 32'h8000_0000);
    check("ovf_flag", {30'd0, rsp_overflow, rsp_negative}, 32'd3);
    check("ovf_sticky_set", {31'd0, ovf_sticky}, 32'd1);
    tick();
    clr_sticky = 1'b1;
    issue(2'b00, 32'h7FFF_FFFF, 32'd1, 1'b0);
    wait_rsp(cycles);
    clr_sticky = 1'b0;
    check("ovf_set_wins", {31'd0, ovf_sticky}, 32'd1);
    tick();
    check("ovf_after_hs", {31'd0, ovf_sticky}, 32'd1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("ovf_cleared", {31'd0, ovf_sticky}, 32'd0);

    // Reset in WAIT with sticky set beforehand
    issue(2'b00, 32'h7FFF_FFFF, 32'd1, 1'b0);
    wait_rsp(cycles);
    tick();
    issue(2'b00, 32'd3, 32'd4, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_ready", {31'd0, req_ready}, 32'd1);
    check("rw_alu_a", alu_a, 32'd0);
    check("rw_alu_b", alu_b, 32'd0);
    check("rw_sticky", {31'd0, ovf_sticky}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("rw_no_rsp", {31'd0, rsp_valid}, 32'd0);
      tick();
    end

    // Chained ADD: operand A comes from the previous result only when chaining is built in
    issue(2'b00, 32'd10, 32'd20, 1'b0);
    wait_rsp(cycles);
    tick();
    issue(2'b00, 32'd99, 32'd5, 1'b1);
`ifdef ALU_SEQ_CHAIN_EN
    check("chain_alu_a", alu_a, 32'd30);
    wait_rsp(cycles);
    check("chain_result", rsp_result, 32'd35);
`else
    check("chain_alu_a", alu_a, 32'd99);
    wait_rsp(cycles);
    check("chain_result", rsp_result, 32'd104);
`endif
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
